// File: rtl/carfield_pkg.sv
// Shared Carfield constants used by the duplex host/island mailbox.
// This file holds the register map, the default FIFO depth, the address-map
// placement and the handshake state type.
package carfield_pkg;

   // Default number of words held by each direction's FIFO.
   localparam int unsigned MboxDepth = 8;

   // Per-side register offsets. Every offset is word-aligned.
   localparam logic [7:0] MboxDataOutOffs = 8'h00;
   localparam logic [7:0] MboxDataInOffs  = 8'h04;
   localparam logic [7:0] MboxStatusOffs  = 8'h08;
   localparam logic [7:0] MboxCtrlOffs    = 8'h0C;
   localparam logic [7:0] MboxErrOffs     = 8'h10;

   // Placement of the mailbox in the host address map.
   localparam logic [63:0] MboxBase = 64'h0000_0000_4000_0000;
   localparam logic [63:0] MboxSize = 64'h0000_0000_0000_1000;

   // Slot of the mailbox in the AXI/reg demux.
   localparam int unsigned CarfieldMboxSlvIdx = 6;

   // The host-side mailbox interrupt adds one external-interrupt line.
   localparam int unsigned CarfieldNumExtIrqBase = 1;
   localparam int unsigned MboxExtIrqIdx         = CarfieldNumExtIrqBase;
   localparam int unsigned CarfieldNumExtIrq     = CarfieldNumExtIrqBase + 1;

   // Two-state request/response handshake used by each register port.
   typedef enum logic {
      MboxIdle = 1'b0,
      MboxResp = 1'b1
   } MboxState;

endpackage

// File: rtl/carfield_mailbox_fifo.sv
// One direction of the mailbox: a circular word buffer with a fill counter.
// A push into a full FIFO is ignored, and so is a pop from an empty FIFO.
// Both decisions use the count as it stands before the clock edge.
module carfield_mailbox_fifo #(
   parameter int unsigned Depth     = 8,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push,
   input  logic [DataWidth-1:0] pushData,
   input  logic                 pop,
   output logic [DataWidth-1:0] headData,
   output logic [CntWidth-1:0]  count,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned PtrWidth = $clog2(Depth);

   logic [DataWidth-1:0] mem [Depth];
   logic [PtrWidth-1:0]  wrPtr;
   logic [PtrWidth-1:0]  rdPtr;
   logic [CntWidth-1:0]  countQ;
   logic                 doPush;
   logic                 doPop;

   assign full     = (countQ == CntWidth'(Depth));
   assign empty    = (countQ == '0);
   assign doPush   = push & ~full;
   assign doPop    = pop & ~empty;
   assign count    = countQ;
   assign headData = mem[rdPtr];

   // Advance the pointers and keep the count in step. The pointers wrap
   // naturally because Depth is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         countQ <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
         if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
         case ({doPush, doPop})
            2'b10:   countQ <= countQ + CntWidth'(1);
            2'b01:   countQ <= countQ - CntWidth'(1);
            default: countQ <= countQ;
         endcase
      end
   end

   // The storage array is not reset. Only slots below the count are ever read.
   always_ff @(posedge clk_i) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/carfield_mailbox_duplex.sv
// Bidirectional mailbox between the host (side A) and an island (side B).
// Each side writes into its own outbound FIFO and reads from the other
// side's outbound FIFO. Each side has a register port and a level interrupt.
module carfield_mailbox_duplex
   import carfield_pkg::*;
#(
   parameter int unsigned Depth     = MboxDepth,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 a_req_valid_i,
   input  logic                 a_req_write_i,
   input  logic [AddrWidth-1:0] a_req_addr_i,
   input  logic [DataWidth-1:0] a_req_wdata_i,
   output logic                 a_rsp_valid_o,
   output logic [DataWidth-1:0] a_rsp_rdata_o,
   output logic                 a_rsp_error_o,
   output logic                 a_irq_o,
   input  logic                 b_req_valid_i,
   input  logic                 b_req_write_i,
   input  logic [AddrWidth-1:0] b_req_addr_i,
   input  logic [DataWidth-1:0] b_req_wdata_i,
   output logic                 b_rsp_valid_o,
   output logic [DataWidth-1:0] b_rsp_rdata_o,
   output logic                 b_rsp_error_o,
   output logic                 b_irq_o
);

   localparam int unsigned CntWidth = $clog2(Depth + 1);

   // Index 0 is side A and index 1 is side B. FIFO f is the one side f pushes into.
   logic [1:0]                reqValid;
   logic [1:0]                reqWrite;
   logic [1:0][AddrWidth-1:0] reqAddr;
   logic [1:0][DataWidth-1:0] reqWdata;
   logic [1:0]                rspValid;
   logic [1:0]                rspError;
   logic [1:0][DataWidth-1:0] rspRdata;
   logic [1:0]                irq;

   logic [1:0]                fifoPush;
   logic [1:0]                fifoPop;
   logic [1:0]                fifoFull;
   logic [1:0]                fifoEmpty;
   logic [1:0][CntWidth-1:0]  fifoCount;
   logic [1:0][DataWidth-1:0] fifoHead;

   assign reqValid = {b_req_valid_i, a_req_valid_i};
   assign reqWrite = {b_req_write_i, a_req_write_i};
   assign reqAddr  = {b_req_addr_i, a_req_addr_i};
   assign reqWdata = {b_req_wdata_i, a_req_wdata_i};

   assign a_rsp_valid_o = rspValid[0];
   assign a_rsp_rdata_o = rspRdata[0];
   assign a_rsp_error_o = rspError[0];
   assign a_irq_o       = irq[0];
   assign b_rsp_valid_o = rspValid[1];
   assign b_rsp_rdata_o = rspRdata[1];
   assign b_rsp_error_o = rspError[1];
   assign b_irq_o       = irq[1];

   for (genvar f = 0; f < 2; f++) begin : gFifo
      carfield_mailbox_fifo #(
         .Depth     (Depth),
         .DataWidth (DataWidth),
         .CntWidth  (CntWidth)
      ) uFifo (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .push     (fifoPush[f]),
         .pushData (reqWdata[f]),
         .pop      (fifoPop[f]),
         .headData (fifoHead[f]),
         .count    (fifoCount[f]),
         .full     (fifoFull[f]),
         .empty    (fifoEmpty[f])
      );
   end

   for (genvar s = 0; s < 2; s++) begin : gSide
      localparam int unsigned Peer = 1 - s;

      MboxState             stateQ;
      logic                 accept;
      logic [CntWidth-1:0]  inCount;
      logic [CntWidth-1:0]  outCount;
      logic                 inEmpty;
      logic                 outFull;
      logic [DataWidth-1:0] inHead;
      logic                 irqEnQ;
      logic [CntWidth-1:0]  irqThreshQ;
      logic [CntWidth-1:0]  effThresh;
      logic                 errPushQ;
      logic                 errPopQ;
      logic                 rspValidQ;
      logic                 rspErrorQ;
      logic [DataWidth-1:0] rspRdataQ;
      logic                 irqQ;
      logic [DataWidth-1:0] rdataNext;
      logic                 errorNext;
      logic                 errPushSet;
      logic                 errPopSet;
      logic                 errPushClr;
      logic                 errPopClr;
      logic                 ctrlWrite;

      assign inCount   = fifoCount[Peer];
      assign outCount  = fifoCount[s];
      assign inEmpty   = fifoEmpty[Peer];
      assign outFull   = fifoFull[s];
      assign inHead    = fifoHead[Peer];
      assign effThresh = (irqThreshQ == '0) ? CntWidth'(1) : irqThreshQ;

      assign accept        = (stateQ == MboxIdle) & reqValid[s];
      assign fifoPush[s]   = accept & reqWrite[s] & (reqAddr[s] == AddrWidth'(MboxDataOutOffs));
      assign fifoPop[Peer] = accept & ~reqWrite[s] & (reqAddr[s] == AddrWidth'(MboxDataInOffs));

      assign rspValid[s] = rspValidQ;
      assign rspError[s] = rspErrorQ;
      assign rspRdata[s] = rspRdataQ;
      assign irq[s]      = irqQ;

      // Decode the pending request into its response data, error flag and CSR effects.
      always_comb begin
         rdataNext  = '0;
         errorNext  = 1'b0;
         errPushSet = 1'b0;
         errPopSet  = 1'b0;
         errPushClr = 1'b0;
         errPopClr  = 1'b0;
         ctrlWrite  = 1'b0;
         case (reqAddr[s])
            AddrWidth'(MboxDataOutOffs): begin
               if (reqWrite[s]) errPushSet = outFull;
               else             errorNext  = 1'b1;
            end
            AddrWidth'(MboxDataInOffs): begin
               if (reqWrite[s])  errorNext = 1'b1;
               else if (inEmpty) errPopSet = 1'b1;
               else              rdataNext = inHead;
            end
            AddrWidth'(MboxStatusOffs): begin
               if (reqWrite[s]) begin
                  errorNext = 1'b1;
               end else begin
                  rdataNext[CntWidth-1:0]  = inCount;
                  rdataNext[8 +: CntWidth] = outCount;
                  rdataNext[16]            = inEmpty;
                  rdataNext[17]            = outFull;
               end
            end
            AddrWidth'(MboxCtrlOffs): begin
               if (reqWrite[s]) begin
                  ctrlWrite = 1'b1;
               end else begin
                  rdataNext[0]             = irqEnQ;
                  rdataNext[8 +: CntWidth] = irqThreshQ;
               end
            end
            AddrWidth'(MboxErrOffs): begin
               if (reqWrite[s]) begin
                  errPushClr = reqWdata[s][0];
                  errPopClr  = reqWdata[s][1];
               end else begin
                  rdataNext[0] = errPushQ;
                  rdataNext[1] = errPopQ;
               end
            end
            default: errorNext = 1'b1;
         endcase
      end

      // Accept a request in IDLE, apply its CSR side effects, and present the
      // response for one cycle. A newly raised error takes priority over a W1C clear.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            stateQ     <= MboxIdle;
            rspValidQ  <= 1'b0;
            rspErrorQ  <= 1'b0;
            rspRdataQ  <= '0;
            irqEnQ     <= 1'b0;
            irqThreshQ <= '0;
            errPushQ   <= 1'b0;
            errPopQ    <= 1'b0;
         end else begin
            case (stateQ)
               MboxIdle: begin
                  if (reqValid[s]) begin
                     stateQ    <= MboxResp;
                     rspValidQ <= 1'b1;
                     rspErrorQ <= errorNext;
                     rspRdataQ <= rdataNext;
                     if (ctrlWrite) begin
                        irqEnQ     <= reqWdata[s][0];
                        irqThreshQ <= reqWdata[s][8 +: CntWidth];
                     end
                     errPushQ <= (errPushQ & ~errPushClr) | errPushSet;
                     errPopQ  <= (errPopQ & ~errPopClr) | errPopSet;
                  end
               end
               MboxResp: begin
                  stateQ    <= MboxIdle;
                  rspValidQ <= 1'b0;
                  rspErrorQ <= 1'b0;
                  rspRdataQ <= '0;
               end
               default: stateQ <= MboxIdle;
            endcase
         end
      end

      // Level interrupt, registered one cycle behind the fill level and error flags.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) irqQ <= 1'b0;
         else         irqQ <= irqEnQ & ((inCount >= effThresh) | errPushQ | errPopQ);
      end
   end

endmodule

// File: tb/tb_carfield_mailbox_duplex.sv
// Scoreboard testbench for the duplex mailbox. Each expected response is
// queued when its request is driven and compared when the DUT answers.
module tb_carfield_mailbox_duplex;

   localparam logic [4:0] OffsDataOut = 5'h00;
   localparam logic [4:0] OffsDataIn  = 5'h04;
   localparam logic [4:0] OffsStatus  = 5'h08;
   localparam logic [4:0] OffsCtrl    = 5'h0C;
   localparam logic [4:0] OffsErr     = 5'h10;
   localparam logic [4:0] OffsBad     = 5'h14;

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      string       tag;
   } Expect;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        aReqValid = 1'b0, aReqWrite = 1'b0;
   logic [4:0]  aReqAddr = '0;
   logic [31:0] aReqWdata = '0;
   logic        bReqValid = 1'b0, bReqWrite = 1'b0;
   logic [4:0]  bReqAddr = '0;
   logic [31:0] bReqWdata = '0;
   logic        aRspValid, aRspError, aIrq;
   logic [31:0] aRspRdata;
   logic        bRspValid, bRspError, bIrq;
   logic [31:0] bRspRdata;

   int          total = 0;
   int          bad = 0;
   Expect       expA[$];
   Expect       expB[$];
   logic [31:0] modelAB[$];
   logic        lastIrqA = 1'b0, lastIrqB = 1'b0;
   logic [31:0] popExp;

   carfield_mailbox_duplex dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .a_req_valid_i (aReqValid),
      .a_req_write_i (aReqWrite),
      .a_req_addr_i  (aReqAddr),
      .a_req_wdata_i (aReqWdata),
      .a_rsp_valid_o (aRspValid),
      .a_rsp_rdata_o (aRspRdata),
      .a_rsp_error_o (aRspError),
      .a_irq_o       (aIrq),
      .b_req_valid_i (bReqValid),
      .b_req_write_i (bReqWrite),
      .b_req_addr_i  (bReqAddr),
      .b_req_wdata_i (bReqWdata),
      .b_rsp_valid_o (bRspValid),
      .b_rsp_rdata_o (bRspRdata),
      .b_rsp_error_o (bRspError),
      .b_irq_o       (bIrq)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // Expected STATUS word as seen from a side with the given inbound and outbound counts.
   function automatic logic [31:0] expStatus(input int inCnt, input int outCnt);
      logic [31:0] w;
      w        = '0;
      w[3:0]   = 4'(inCnt);
      w[11:8]  = 4'(outCnt);
      w[16]    = (inCnt == 0);
      w[17]    = (outCnt == 8);
      return w;
   endfunction

   // Queue the expected response, drive one request, and wait a bounded time
   // for the one-cycle response. Then wait one more edge so the port is idle again.
   task automatic applyStimulus(input int side, input logic wr, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input logic expErr, input string tag);
      Expect e;
      bit    seen = 1'b0;
      int    cycles = 0;
      e.rdata = expRdata;
      e.error = expErr;
      e.tag   = tag;
      if (side == 0) expA.push_back(e);
      else           expB.push_back(e);
      @(negedge clk);
      if (side == 0) begin
         aReqValid = 1'b1; aReqWrite = wr; aReqAddr = addr; aReqWdata = wdata;
      end else begin
         bReqValid = 1'b1; bReqWrite = wr; bReqAddr = addr; bReqWdata = wdata;
      end
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         seen = (side == 0) ? aRspValid : bRspValid;
      end
      if (side == 0) begin
         aReqValid = 1'b0;
         lastIrqA  = aIrq;
      end else begin
         bReqValid = 1'b0;
         lastIrqB  = bIrq;
      end
      if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      else       checkOutput({tag, "_latency"}, 32'(cycles), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two cycles. Flush the scoreboard and model, and check the
   // outputs while reset is held.
   task automatic doReset();
      rstN = 1'b0;
      aReqValid = 1'b0;
      bReqValid = 1'b0;
      expA.delete();
      expB.delete();
      modelAB.delete();
      repeat (2) @(negedge clk);
      checkOutput("rst_a_rsp_valid", 32'(aRspValid), 32'd0);
      checkOutput("rst_b_rsp_valid", 32'(bRspValid), 32'd0);
      checkOutput("rst_irqs", {30'd0, aIrq, bIrq}, 32'd0);
      rstN = 1'b1;
   endtask

   // Compare each response against the head of its side's queue.
   always @(negedge clk) begin : monitor
      Expect e;
      if (aRspValid) begin
         if (expA.size() == 0) begin
            checkOutput("a_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = expA.pop_front();
            checkOutput({e.tag, "_rdata"}, aRspRdata, e.rdata);
            checkOutput({e.tag, "_err"}, 32'(aRspError), 32'(e.error));
         end
      end
      if (bRspValid) begin
         if (expB.size() == 0) begin
            checkOutput("b_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = expB.pop_front();
            checkOutput({e.tag, "_rdata"}, bRspRdata, e.rdata);
            checkOutput({e.tag, "_err"}, 32'(bRspError), 32'(e.error));
         end
      end
   end

   // Stop the run if it is still going far beyond the expected runtime.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, then a STATUS read from A.
      doReset();
      applyStimulus(0, 1'b0, OffsStatus, '0, 32'h0001_0000, 1'b0, "a_status_reset");
      checkOutput("irqs_after_reset", {30'd0, aIrq, bIrq}, 32'd0);

      // Send two words from A to B and read them back in order.
      applyStimulus(0, 1'b1, OffsDataOut, 32'hDEADBEEF, '0, 1'b0, "a_push0");
      applyStimulus(0, 1'b1, OffsDataOut, 32'h12345678, '0, 1'b0, "a_push1");
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(2, 0), 1'b0, "b_status2");
      applyStimulus(1, 1'b0, OffsDataIn, '0, 32'hDEADBEEF, 1'b0, "b_pop0");
      applyStimulus(1, 1'b0, OffsDataIn, '0, 32'h12345678, 1'b0, "b_pop1");
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(0, 0), 1'b0, "b_status_empty");

      // B's interrupt tracks its inbound level with threshold 3.
      doReset();
      applyStimulus(1, 1'b1, OffsCtrl, 32'h0000_0301, '0, 1'b0, "b_ctrl_wr");
      applyStimulus(1, 1'b0, OffsCtrl, '0, 32'h0000_0301, 1'b0, "b_ctrl_rd");
      applyStimulus(0, 1'b1, OffsDataOut, 32'h1111_0001, '0, 1'b0, "irq_push1");
      applyStimulus(0, 1'b1, OffsDataOut, 32'h1111_0002, '0, 1'b0, "irq_push2");
      checkOutput("b_irq_below_thresh", 32'(bIrq), 32'd0);
      applyStimulus(0, 1'b1, OffsDataOut, 32'h1111_0003, '0, 1'b0, "irq_push3");
      checkOutput("b_irq_not_yet", 32'(lastIrqA == 1'b0 ? 1'b0 : 1'b1), 32'd0);
      checkOutput("b_irq_at_accept_edge", 32'(bIrq), 32'd1);
      applyStimulus(1, 1'b0, OffsDataIn, '0, 32'h1111_0001, 1'b0, "irq_pop");
      checkOutput("b_irq_held_at_pop", 32'(lastIrqB), 32'd1);
      checkOutput("b_irq_fall", 32'(bIrq), 32'd0);
      checkOutput("a_irq_idle", 32'(aIrq), 32'd0);

      // Overflow: the 9th push is dropped and sets ERR[0]. Drain, then clear.
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 1'b1, OffsDataOut, 32'hA000_0000 + 32'(i), '0, 1'b0, "ovf_push");
         if (i < 8) modelAB.push_back(32'hA000_0000 + 32'(i));
      end
      applyStimulus(0, 1'b0, OffsErr, '0, 32'h1, 1'b0, "a_err_ovf");
      applyStimulus(0, 1'b0, OffsStatus, '0, expStatus(0, 8), 1'b0, "a_status_full");
      while (modelAB.size() > 0) begin
         popExp = modelAB.pop_front();
         applyStimulus(1, 1'b0, OffsDataIn, '0, popExp, 1'b0, "drain_pop");
      end
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(0, 0), 1'b0, "b_status_drained");
      applyStimulus(0, 1'b1, OffsErr, 32'h1, '0, 1'b0, "a_err_w1c");
      applyStimulus(0, 1'b0, OffsErr, '0, 32'h0, 1'b0, "a_err_cleared");

      // A push and a B pop on the same edge, at mid-fill, full and empty.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b1, OffsDataOut, 32'hC0DE_0000 + 32'(i), '0, 1'b0, "sim_fill");
         modelAB.push_back(32'hC0DE_0000 + 32'(i));
      end
      popExp = modelAB.pop_front();
      modelAB.push_back(32'hC0DE_0004);
      fork
         applyStimulus(0, 1'b1, OffsDataOut, 32'hC0DE_0004, '0, 1'b0, "sim_mid_push");
         applyStimulus(1, 1'b0, OffsDataIn, '0, popExp, 1'b0, "sim_mid_pop");
      join
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(4, 0), 1'b0, "b_status_mid");
      while (modelAB.size() < 8) begin
         modelAB.push_back(32'hC0DE_0010 + 32'(modelAB.size()));
         applyStimulus(0, 1'b1, OffsDataOut, modelAB[$], '0, 1'b0, "sim_fill_full");
      end
      popExp = modelAB.pop_front();
      fork
         applyStimulus(0, 1'b1, OffsDataOut, 32'hBAD0_0000, '0, 1'b0, "sim_full_push");
         applyStimulus(1, 1'b0, OffsDataIn, '0, popExp, 1'b0, "sim_full_pop");
      join
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(7, 0), 1'b0, "b_status_after_full");
      applyStimulus(0, 1'b0, OffsErr, '0, 32'h1, 1'b0, "a_err_sim_full");
      while (modelAB.size() > 0) begin
         popExp = modelAB.pop_front();
         applyStimulus(1, 1'b0, OffsDataIn, '0, popExp, 1'b0, "sim_drain");
      end
      modelAB.push_back(32'hE0E0_0001);
      fork
         applyStimulus(0, 1'b1, OffsDataOut, 32'hE0E0_0001, '0, 1'b0, "sim_empty_push");
         applyStimulus(1, 1'b0, OffsDataIn, '0, 32'h0, 1'b0, "sim_empty_pop");
      join
      applyStimulus(1, 1'b0, OffsErr, '0, 32'h2, 1'b0, "b_err_underflow");
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(1, 0), 1'b0, "b_status_one");

      // Illegal accesses return error=1 and leave all state unchanged.
      applyStimulus(0, 1'b0, OffsBad, '0, 32'h0, 1'b1, "a_bad_offs");
      applyStimulus(0, 1'b1, OffsStatus, 32'hFFFF_FFFF, '0, 1'b1, "a_wr_status");
      applyStimulus(0, 1'b0, OffsDataOut, '0, 32'h0, 1'b1, "a_rd_dataout");
      applyStimulus(1, 1'b1, OffsDataIn, 32'h5555_5555, '0, 1'b1, "b_wr_datain");
      applyStimulus(0, 1'b0, OffsStatus, '0, expStatus(0, 1), 1'b0, "a_status_unchanged");
      applyStimulus(0, 1'b0, OffsErr, '0, 32'h1, 1'b0, "a_err_unchanged");
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(1, 0), 1'b0, "b_status_unchanged");

      // Reset asserted during RESP drops the response immediately and empties both FIFOs.
      applyStimulus(1, 1'b1, OffsDataOut, 32'h7777_0000, '0, 1'b0, "b_push_pre_rst");
      @(negedge clk);
      aReqValid = 1'b1; aReqWrite = 1'b0; aReqAddr = OffsStatus; aReqWdata = '0;
      @(posedge clk);
      #1;
      checkOutput("rsp_before_rst", 32'(aRspValid), 32'd1);
      rstN = 1'b0;
      aReqValid = 1'b0;
      #1;
      checkOutput("rsp_drop_on_rst", 32'(aRspValid), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      modelAB.delete();
      applyStimulus(0, 1'b0, OffsStatus, '0, expStatus(0, 0), 1'b0, "a_status_post_rst");
      applyStimulus(1, 1'b0, OffsStatus, '0, expStatus(0, 0), 1'b0, "b_status_post_rst");

      @(negedge clk);
      checkOutput("scoreboard_drained", 32'(expA.size() + expB.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/carfield_mailbox_duplex.md
Name: carfield_mailbox_duplex

Overview:
- Bidirectional word mailbox between the Cheshire host (side A) and an island (side B), for example the security or safety island.
- The existing mailbox path only carries host-initiated messages. This block adds the return direction. Each side pushes into its own outbound FIFO and pops its inbound FIFO, which is the other side's outbound FIFO.
- Each side gets a level interrupt driven by its inbound fill level. The host interrupt feeds the external-interrupt vector.
- Both sides are accessed through simple request/response register ports.

Parameters:
- Depth, 8, words per direction FIFO (power of 2, >=2).
- DataWidth, 32, message word width (matches narrow AXI data width).
- AddrWidth, 5, register offset width per port.
- CntWidth, $clog2(Depth+1), derived; not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- a_req_valid_i  in  1  side A request, held until a_rsp_valid_o
- a_req_write_i  in  1  1=write, 0=read
- a_req_addr_i  in  AddrWidth  byte offset
- a_req_wdata_i  in  DataWidth  write data
- a_rsp_valid_o  out  1  one-cycle response strobe
- a_rsp_rdata_o  out  DataWidth  read data, valid with a_rsp_valid_o
- a_rsp_error_o  out  1  access error, valid with a_rsp_valid_o
- a_irq_o  out  1  side A interrupt
- b_req_valid_i, b_req_write_i, b_req_addr_i, b_req_wdata_i, b_rsp_valid_o, b_rsp_rdata_o, b_rsp_error_o, b_irq_o: identical for side B

Behaviour:
- Reset (async, rst_ni=0):
  - Both FIFOs are empty.
  - All CTRL and ERR fields are 0.
  - All rsp_* and irq outputs are 0.
  - A request in flight during reset is dropped; the requester must reissue it.
- Port handshake, each side independent, two-state FSM IDLE -> RESP -> IDLE:
  - In IDLE, req_valid_i=1 is accepted. The side effect (push/pop/CSR update) happens on that edge, and the FSM moves to RESP.
  - In RESP, rsp_valid_o=1 for exactly one cycle with registered rdata/error. The FSM then returns to IDLE.
  - Latency is 1 cycle. Maximum throughput is one access per 2 cycles.
  - A request is never sampled in the RESP cycle.
  - rdata is 0 on writes and on errors.
- Register map per side (offsets word-aligned):
  - 0x00 DATA_OUT (W): push wdata into own outbound FIFO.
  - 0x04 DATA_IN (R): pop the inbound FIFO head.
  - 0x08 STATUS (R):
    - [CntWidth-1:0] = inbound count.
    - [8+CntWidth-1:8] = outbound count.
    - [16] = inbound empty.
    - [17] = outbound full.
  - 0x0C CTRL (RW):
    - [0] = irq_en.
    - [8+CntWidth-1:8] = irq_thresh; 0 is treated as 1.
  - 0x10 ERR (R, W1C):
    - [0] = push-on-full.
    - [1] = pop-on-empty.
  - Reads of DATA_OUT, writes of DATA_IN/STATUS, and any other offset: error=1, no side effect.
- Boundary conditions:
  - Push while the outbound FIFO is full: data is dropped, ERR[0] is set, error=0. Fullness is judged on the pre-edge count, even if the other side pops on the same edge.
  - Pop while the inbound FIFO is empty: rdata=0, ERR[1] is set, error=0. Emptiness is judged on the pre-edge count, even if the other side pushes on the same edge.
  - Simultaneous push by the owner and pop by the peer on the same FIFO in the same cycle (FIFO neither full nor empty): both occur and the count is unchanged.
  - W1C on ERR in the same cycle a new error is raised: set wins.
- FIFO storage and count rules:
  - Each direction FIFO uses log2(Depth)-bit wrapping read/write pointers plus a CntWidth counter.
  - Count stays within 0..Depth. Pointers wrap Depth-1 -> 0.
- Interrupt:
  - Registered (1-cycle after the state change).
  - Condition: irq_o = irq_en & (inbound_count >= max(irq_thresh,1) | |ERR).
  - Level-sensitive. It deasserts one cycle after the condition clears.

Decomposition:
- carfield_pkg gains:
  - register offset constants MboxDataOutOffs..MboxErrOffs;
  - MboxDepth=8;
  - the mailbox base address and size, with index entries for the AXI/reg demux and the external-interrupt count update.
- Natural sub-module: carfield_mailbox_fifo (one direction: push, pop, count, full, empty, head data). It is instantiated twice: A->B and B->A.
- The per-side register FSM is written once as a generate loop over the two sides.

Test Plan:
- Reset, then A reads STATUS -> rsp 1 cycle after accept, rdata=0x00010000 (inbound empty), error=0, both irqs 0.
- A writes 0xDEADBEEF, 0x12345678 to DATA_OUT; B reads STATUS -> inbound count 2. B reads DATA_IN twice -> 0xDEADBEEF then 0x12345678, and STATUS shows empty.
- B sets CTRL irq_en=1, thresh=3; A pushes 3 words -> b_irq_o rises the cycle after the 3rd push. B pops one -> b_irq_o falls one cycle after the pop.
- A pushes 9 words -> 9th push: error=0, A's ERR=0x1. B drains and receives exactly 8 words in order. A writes ERR=0x1 -> ERR=0.
- Same-cycle A push and B pop with the A->B FIFO holding 4 -> count stays 4. With the FIFO full (8) -> A's push flagged in ERR[0], count 7. With the FIFO empty -> B's pop flagged in ERR[1] (rdata 0), count 1.
- Read at offset 0x14 and write to STATUS -> error=1, no state change. rst_ni pulsed low mid-RESP -> rsp_valid_o drops immediately and both FIFOs are empty.
